// File: rtl/lsu_dmem_if.sv
// lsu_dmem_if: request/response handshake bundle between the LSU MEM stage
// (master) and the data-memory controller (slave).
//   req_valid/req_ready  request handshake; req_we, req_funct3, req_addr and
//                        req_wdata describe the access
//   rsp_valid/rsp_ready  response handshake; rsp_rdata is the extended load
//                        data and rsp_err flags a faulted access
`timescale 1ns/1ps
interface lsu_dmem_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_dmem_ctrl.sv
// lsu_dmem_ctrl: handshaked RV32 data-memory slave. Byte/half/word loads
// (signed and unsigned) and byte-lane-masked stores into a word-organised
// RAM, with WAIT_STATES extra cycles between accept and response.
// Ports:
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    lsu_dmem_if.slave: request and response handshakes
// Configuration macro LSU_DMEM_ERR_EN: when defined, misaligned and
// out-of-range accesses fault (rsp_err=1, no write, rdata=0); otherwise
// misaligned accesses are aligned down and upper address bits alias.
// Illegal funct3 always faults.
//
// state  | meaning
// S_IDLE | ready for a request; req_ready=1
// S_WAIT | access accepted, counting wait states
// S_RESP | response presented until rsp_ready
`timescale 1ns/1ps
module lsu_dmem_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  lsu_dmem_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int WS_M1 = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [3:0] WAIT_LOAD = 4'(WS_M1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t state, state_nxt;
  logic [3:0] wait_cnt;
  logic [31:0] mem [DEPTH_WORDS];

  logic             lat_we;
  logic             lat_err;
  logic [2:0]       lat_f3;
  logic [IDX_W-1:0] lat_idx;
  logic [1:0]       lat_off;

  logic [31:0] rdata_q;
  logic        err_q;

  logic             accept;
  logic [IDX_W-1:0] req_idx;
  logic             illegal, misaligned, out_of_range, req_err;

  assign accept  = bus.req_valid && bus.req_ready;
  assign req_idx = bus.req_addr[IDX_W+1:2];

  always_comb begin
    if (bus.req_we) illegal = (bus.req_funct3 > 3'b010);
    else illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
  end

`ifdef LSU_DMEM_ERR_EN
  assign misaligned   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                        ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  assign out_of_range = (bus.req_addr[ADDR_W-1:IDX_W+2] != '0);
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[ADDR_W-1:IDX_W+2];
  assign misaligned     = 1'b0;
  assign out_of_range   = 1'b0;
`endif

  assign req_err = illegal || misaligned || out_of_range;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (wait_cnt == 4'd0) state_nxt = S_RESP;
      S_RESP: if (bus.rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.req_ready = (state == S_IDLE);
    bus.rsp_valid = (state == S_RESP);
  end

  // Down-counter: WAIT is left when it reaches zero, giving WAIT_STATES cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 4'd0;
    else if (state == S_IDLE && accept) wait_cnt <= WAIT_LOAD;
    else if (state == S_WAIT && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we  <= 1'b0;
      lat_err <= 1'b0;
      lat_f3  <= 3'b000;
      lat_idx <= '0;
      lat_off <= 2'b00;
    end else if (accept) begin
      lat_we  <= bus.req_we;
      lat_err <= req_err;
      lat_f3  <= bus.req_funct3;
      lat_idx <= req_idx;
      lat_off <= bus.req_addr[1:0];
    end
  end

  // With zero wait states RESP is entered on the accept edge itself, so the
  // load path must see the live request rather than the latched copy.
  logic             cur_we, cur_err;
  logic [2:0]       cur_f3;
  logic [IDX_W-1:0] cur_idx;
  logic [1:0]       cur_off;
  logic [31:0]      cur_word, ld_data;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;

  always_comb begin
    if (state == S_IDLE) begin
      cur_we  = bus.req_we;
      cur_err = req_err;
      cur_f3  = bus.req_funct3;
      cur_idx = req_idx;
      cur_off = bus.req_addr[1:0];
    end else begin
      cur_we  = lat_we;
      cur_err = lat_err;
      cur_f3  = lat_f3;
      cur_idx = lat_idx;
      cur_off = lat_off;
    end
  end

  always_comb begin
    cur_word = mem[cur_idx];
    ld_byte  = cur_word[{cur_off, 3'b000} +: 8];
    ld_half  = cur_off[1] ? cur_word[31:16] : cur_word[15:0];
    case (cur_f3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = cur_word;
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = 32'd0;
    endcase
    if (cur_we || cur_err) ld_data = 32'd0;
  end

  // Response registers only change on entry to RESP, so they hold through
  // any amount of back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (state_nxt == S_RESP && state != S_RESP) begin
      rdata_q <= ld_data;
      err_q   <= cur_err;
    end
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        wr_en;

  always_comb begin
    case (bus.req_funct3[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << bus.req_addr[1:0];
        wr_data = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        wr_be   = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = bus.req_wdata;
      end
    endcase
  end

  assign wr_en = rst_n && accept && bus.req_we && !req_err;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[req_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
`timescale 1ns/1ps
module tb_lsu_dmem_ctrl;
  localparam int WS    = 3;
  localparam int DEPTH = 256;
`ifdef LSU_DMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_dmem_if #(.ADDR_W(32)) bus ();

  lsu_dmem_ctrl #(
    .ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request and wait for it to be accepted.
  task automatic issue(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err);
    int guard;
    exp_q.push_back('{tag, exp_rd, exp_err});
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!bus.req_ready) check_val({tag, " accept_timeout"}, 32'd0, 32'd1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Wait for the response, compare against the scoreboard, back-pressure
  // for 'hold' cycles, then complete the handshake.
  task automatic collect(input int hold);
    exp_t e;
    int lat;
    e = exp_q.pop_front();
    lat = 0;
    while (!bus.rsp_valid && lat < 50) begin
      tick();
      lat++;
    end
    check_val({e.tag, " latency"}, 32'(lat), 32'(WS));
    if (!bus.rsp_valid) return;
    check_val({e.tag, " rdata"}, bus.rsp_rdata, e.rdata);
    check_val({e.tag, " err"}, {31'd0, bus.rsp_err}, {31'd0, e.err});
    for (int i = 0; i < hold; i++) begin
      tick();
      check_val({e.tag, " hold_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
      check_val({e.tag, " hold_rdata"}, bus.rsp_rdata, e.rdata);
      check_val({e.tag, " hold_err"}, {31'd0, bus.rsp_err}, {31'd0, e.err});
      check_val({e.tag, " hold_ready"}, {31'd0, bus.req_ready}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check_val({e.tag, " idle_after"}, {bus.rsp_valid, bus.req_ready}, 32'b01);
  endtask

  task automatic xfer(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_err, input int hold);
    issue(tag, we, f3, addr, wdata, exp_rd, exp_err);
    collect(hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] rnd_addr [6];
  logic [31:0] rnd_data [6];

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.rsp_ready  = 1'b0;
    #1;
    check_val("rst ready",  {31'd0, bus.req_ready}, 32'd1);
    check_val("rst valid",  {31'd0, bus.rsp_valid}, 32'd0);
    check_val("rst err",    {31'd0, bus.rsp_err},   32'd0);
    check_val("rst rdata",  bus.rsp_rdata,          32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // sign/zero extension
    xfer("sw_deadbeef", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    xfer("lb_13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 0);
    xfer("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0, 0);
    xfer("lh_12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 0);
    xfer("lhu_10", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, 0);
    xfer("lbu_11", 1'b0, 3'b100, 32'h11, 32'h0, 32'h000000BE, 1'b0, 0);

    // lane-masked stores, then a held response
    xfer("sw_20", 1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1'b0, 0);
    xfer("sb_21", 1'b1, 3'b000, 32'h21, 32'hFFFFFFAA, 32'h0, 1'b0, 0);
    xfer("sh_22", 1'b1, 3'b001, 32'h22, 32'hFFFF5566, 32'h0, 1'b0, 0);
    xfer("lw_20_hold", 1'b0, 3'b010, 32'h20, 32'h0, 32'h5566AA44, 1'b0, 5);

    // illegal funct3
    xfer("ld_f3_011", 1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1, 0);
    xfer("ld_f3_110", 1'b0, 3'b110, 32'h20, 32'h0, 32'h0, 1'b1, 0);
    xfer("st_f3_101", 1'b1, 3'b101, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b1, 0);

    // reset in the middle of WAIT: response dropped, store already written
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h40;
    bus.req_wdata  = 32'hCAFEF00D;
    bus.req_valid  = 1'b1;
    tick();
    bus.req_valid  = 1'b0;
    tick();
    check_val("midwait ready", {31'd0, bus.req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check_val("async valid", {31'd0, bus.rsp_valid}, 32'd0);
    check_val("async ready", {31'd0, bus.req_ready}, 32'd1);
    check_val("async err",   {31'd0, bus.rsp_err},   32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_val("post_rst valid", {31'd0, bus.rsp_valid}, 32'd0);
    xfer("lw_40_kept", 1'b0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 0);
    xfer("lw_20_unch", 1'b0, 3'b010, 32'h20, 32'h0, 32'h5566AA44, 1'b0, 0);

    // misaligned and out-of-range behaviour depends on the build
    xfer("lw_22_mis", 1'b0, 3'b010, 32'h22, 32'h0,
         ERR_EN ? 32'h0 : 32'h5566AA44, ERR_EN, 0);
    xfer("lh_11_mis", 1'b0, 3'b001, 32'h11, 32'h0,
         ERR_EN ? 32'h0 : 32'hFFFFBEEF, ERR_EN, 0);
    xfer("sw_0", 1'b1, 3'b010, 32'h0, 32'h01020304, 32'h0, 1'b0, 0);
    xfer("sw_oor", 1'b1, 3'b010, 32'(DEPTH * 4), 32'h0BADBEEF, 32'h0, ERR_EN, 0);
    xfer("lw_0", 1'b0, 3'b010, 32'h0, 32'h0,
         ERR_EN ? 32'h01020304 : 32'h0BADBEEF, 1'b0, 0);

    // scattered word stores, then read back
    for (int i = 0; i < 6; i++) begin
      rnd_addr[i] = 32'((16 + i * 5 + int'($urandom_range(0, 3))) * 4);
      rnd_data[i] = $urandom;
      xfer("rnd_sw", 1'b1, 3'b010, rnd_addr[i], rnd_data[i], 32'h0, 1'b0, 0);
    end
    for (int i = 0; i < 6; i++) begin
      xfer("rnd_lw", 1'b0, 3'b010, rnd_addr[i], 32'h0, rnd_data[i], 1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
